// File: rtl/bus_xfer_sequencer.sv
// Command-driven generator of one-hot bus source/destination strobes, fed from a small FIFO.
// Optional macro BUSSEQ_FAST_EN: non-MDR sources skip DRIVE and go straight to LATCH.
module bus_xfer_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CODE_W     = 5
) (
    input  logic              clock_i,
    input  logic              clear_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CODE_W-1:0] cmd_src_i,
    input  logic [CODE_W-1:0] cmd_dst_i,
    input  logic              mem_ready_i,
    input  logic              stall_i,
    output logic [23:0]       src_out_o,
    output logic [23:0]       dst_in_o,
    output logic              xfer_done_o,
    output logic              cmd_err_o,
    output logic              busy_o
);
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = PTR_W + 1;
    localparam int NUM_CODES = 24;
    localparam int SRC_MDR   = 21;

    // IDLE: no transfer | DRIVE: source only | WAIT: MDR source, memory not ready | LATCH: source + dest
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_LATCH} state_t;

    logic [CODE_W-1:0] src_mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0] dst_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q;
    logic              push, pop, can_pop;
    state_t            state_q, state_d;
    logic [23:0]       src_q, src_d, dst_q, dst_d, pend_q, pend_d;
    logic              done_q, done_d, err_q, err_d;
    logic [CODE_W-1:0] head_src, head_dst;
    logic              head_legal;

    function automatic logic [23:0] onehot(input logic [CODE_W-1:0] code);
        onehot = 24'd1 << code;
    endfunction

    assign push       = cmd_valid_i && ready_q;
    assign head_src   = src_mem_q[rd_ptr_q];
    assign head_dst   = dst_mem_q[rd_ptr_q];
    assign head_legal = (int'(head_src) < NUM_CODES) && (int'(head_dst) < NUM_CODES);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        can_pop = (count_q != '0) && !stall_i;
        case (state_q)
            S_IDLE: begin
                src_d = '0;
                dst_d = '0;
                pop   = can_pop;
            end
            S_DRIVE: begin
                if (!stall_i) begin
                    if (src_q[SRC_MDR] && !mem_ready_i) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_LATCH;
                        dst_d   = pend_q;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!stall_i && mem_ready_i) begin
                    state_d = S_LATCH;
                    dst_d   = pend_q;
                    done_d  = 1'b1;
                end
            end
            S_LATCH: begin
                if (!stall_i) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        src_d   = '0;
                        dst_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An illegal command is consumed here and replaced by a single error cycle.
        if (pop) begin
            pend_d = onehot(head_dst);
            if (!head_legal) begin
                state_d = S_IDLE;
                src_d   = '0;
                dst_d   = '0;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end else begin
                src_d = onehot(head_src);
`ifdef BUSSEQ_FAST_EN
                if (int'(head_src) != SRC_MDR) begin
                    state_d = S_LATCH;
                    dst_d   = onehot(head_dst);
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRIVE;
                    dst_d   = '0;
                    done_d  = 1'b0;
                end
`else
                state_d = S_DRIVE;
                dst_d   = '0;
                done_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            pend_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            src_q   <= src_d;
            dst_q   <= dst_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            src_mem_q[wr_ptr_q] <= cmd_src_i;
            dst_mem_q[wr_ptr_q] <= cmd_dst_i;
        end
    end

    assign cmd_ready_o = ready_q;
    assign src_out_o   = src_q;
    assign dst_in_o    = dst_q;
    assign xfer_done_o = done_q;
    assign cmd_err_o   = err_q;
    assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer: directed scenarios plus a randomized command stream
// compared against an expected per-cycle strobe list built from the transfer timing rules.
module tb_bus_xfer_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int CODE_W     = 5;

    logic              clk = 1'b0;
    logic              clear = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CODE_W-1:0] cmd_src = '0;
    logic [CODE_W-1:0] cmd_dst = '0;
    logic              mem_ready = 1'b1;
    logic              stall = 1'b0;
    logic [23:0]       src_out, dst_in;
    logic              xfer_done, cmd_err, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_xfer_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .CODE_W(CODE_W)) dut (
        .clock_i    (clk),
        .clear_i    (clear),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_src_i  (cmd_src),
        .cmd_dst_i  (cmd_dst),
        .mem_ready_i(mem_ready),
        .stall_i    (stall),
        .src_out_o  (src_out),
        .dst_in_o   (dst_in),
        .xfer_done_o(xfer_done),
        .cmd_err_o  (cmd_err),
        .busy_o     (busy)
    );

    task automatic do_reset();
        clear = 1'b1; cmd_valid = 1'b0; stall = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear = 1'b1; cmd_valid = 1'b1; cmd_src = 5'd3; cmd_dst = 5'd4;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({src_out, dst_in, xfer_done, cmd_err, busy, cmd_ready} !== 51'b0) begin
            errors++;
            $display("FAIL reset_outputs got src=%h dst=%h done=%b err=%b busy=%b ready=%b exp all zero",
                     src_out, dst_in, xfer_done, cmd_err, busy, cmd_ready);
        end
        clear = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if ({src_out, dst_in, cmd_err} !== 49'b0) begin
                errors++;
                $display("FAIL reset_no_ghost t=%0d got src=%h dst=%h err=%b exp zero", t, src_out, dst_in, cmd_err);
            end
        end
    endtask

    task automatic test_single();
        logic [23:0] es, ed;
        logic        edn, eb;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            if (t > 0) begin
                es  = (t == 2 || t == 3) ? 24'h000004 : 24'h0;
                ed  = (t == 3) ? 24'h000020 : 24'h0;
                edn = (t == 3);
                eb  = (t <= 3);
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err, busy} !== {es, ed, edn, 1'b0, eb}) begin
                    errors++;
                    $display("FAIL single t=%0d got src=%h dst=%h done=%b err=%b busy=%b exp src=%h dst=%h done=%b err=0 busy=%b",
                             t, src_out, dst_in, xfer_done, cmd_err, busy, es, ed, edn, eb);
                end
            end
            cmd_valid = (t == 0); cmd_src = 5'd2; cmd_dst = 5'd5;
            @(negedge clk);
        end
    endtask

    task automatic test_mdr_wait();
        logic [23:0] es, ed;
        logic        edn;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            if (t > 0) begin
                es  = (t >= 2 && t <= 6) ? 24'h200000 : 24'h0;
                ed  = (t == 6) ? 24'h100000 : 24'h0;
                edn = (t == 6);
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {es, ed, edn, 1'b0}) begin
                    errors++;
                    $display("FAIL mdr_wait t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=%h done=%b err=0",
                             t, src_out, dst_in, xfer_done, cmd_err, es, ed, edn);
                end
            end
            cmd_valid = (t == 0); cmd_src = 5'd21; cmd_dst = 5'd20;
            mem_ready = (t >= 5);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  bs[5];
        logic [4:0]  bd[5];
        logic [23:0] es, ed;
        logic        edn;
        int          j;
        bs = '{5'd1, 5'd3, 5'd7, 5'd22, 5'd23};
        bd = '{5'd2, 5'd4, 5'd8, 5'd23, 5'd22};
        do_reset();
        for (int t = 0; t < 17; t++) begin
            if (t > 0) begin
                es = 24'h0; ed = 24'h0; edn = 1'b0;
                if (t >= 5 && t <= 14) begin
                    j   = t - 5;
                    es  = 24'd1 << bs[j / 2];
                    ed  = (j % 2 == 1) ? (24'd1 << bd[j / 2]) : 24'h0;
                    edn = (j % 2 == 1);
                end
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {es, ed, edn, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=%h done=%b err=0",
                             t, src_out, dst_in, xfer_done, cmd_err, es, ed, edn);
                end
            end
            if (t == 4) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full got ready=%b exp ready=0", cmd_ready);
                end
            end
            if (t == 5) begin
                checks++;
                if (cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_reopen got ready=%b exp ready=1", cmd_ready);
                end
            end
            if (t == 16) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle got busy=%b exp busy=0", busy);
                end
            end
            stall     = (t < 4);
            cmd_valid = (t < 4) || (t == 5);
            cmd_src   = bs[(t < 4) ? t : 4];
            cmd_dst   = bd[(t < 4) ? t : 4];
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [23:0] es, ed;
        logic        edn, eer;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            if (t > 0) begin
                es  = (t == 3 || t == 4) ? 24'h010000 : 24'h0;
                ed  = (t == 4) ? 24'h000001 : 24'h0;
                edn = (t == 4);
                eer = (t == 2);
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {es, ed, edn, eer}) begin
                    errors++;
                    $display("FAIL illegal t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=%h done=%b err=%b",
                             t, src_out, dst_in, xfer_done, cmd_err, es, ed, edn, eer);
                end
            end
            cmd_valid = (t <= 1);
            cmd_src   = (t == 0) ? 5'd30 : 5'd16;
            cmd_dst   = (t == 0) ? 5'd1  : 5'd0;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [23:0] es, ed;
        logic        edn;
        do_reset();
        for (int t = 0; t < 11; t++) begin
            if (t > 0) begin
                es  = (t >= 2 && t <= 6) ? 24'h000010 : ((t == 7 || t == 8) ? 24'h000040 : 24'h0);
                ed  = (t >= 3 && t <= 6) ? 24'h000200 : ((t == 8) ? 24'h000080 : 24'h0);
                edn = (t == 3 || t == 8);
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {es, ed, edn, 1'b0}) begin
                    errors++;
                    $display("FAIL stall t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=%h done=%b err=0",
                             t, src_out, dst_in, xfer_done, cmd_err, es, ed, edn);
                end
            end
            cmd_valid = (t <= 1);
            cmd_src   = (t == 0) ? 5'd4 : 5'd6;
            cmd_dst   = (t == 0) ? 5'd9 : 5'd7;
            stall     = (t >= 3 && t <= 5);
            @(negedge clk);
        end
    endtask

    task automatic test_clear_wait();
        logic [23:0] es;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            if (t > 0) begin
                es = (t == 2 || t == 3) ? 24'h200000 : 24'h0;
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {es, 24'h0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL clear_wait t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=0 done=0 err=0",
                             t, src_out, dst_in, xfer_done, cmd_err, es);
                end
            end
            if (t == 4) begin
                checks++;
                if (busy !== 1'b0 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_state got busy=%b ready=%b exp busy=0 ready=0", busy, cmd_ready);
                end
            end
            if (t == 6) begin
                checks++;
                if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_empty got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready);
                end
            end
            cmd_valid = (t <= 1);
            cmd_src   = (t == 0) ? 5'd21 : 5'd1;
            cmd_dst   = (t == 0) ? 5'd10 : 5'd2;
            mem_ready = (t >= 3);
            clear     = (t == 3);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        localparam int N = 16;
        logic [4:0]  rs[N];
        logic [4:0]  rdst[N];
        bit          mr[256];
        logic [23:0] es[256];
        logic [23:0] ed[256];
        bit          edn[256];
        bit          eer[256];
        logic [23:0] xs, xd;
        logic        xdn, xer;
        int          len, np, u, j;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 7) == 0)      rs[k] = 5'(24 + $urandom_range(0, 7));
            else if ($urandom_range(0, 3) == 0) rs[k] = 5'd21;
            else                                rs[k] = 5'($urandom_range(0, 23));
            rdst[k] = ($urandom_range(0, 9) == 0) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom_range(0, 23));
        end
        for (int i = 0; i < 256; i++)
            mr[i] = ($urandom_range(0, 2) != 0) || (i % 5 == 4);
        // Expected cycle list: illegal = 1 error cycle; legal = source cycles then one latch cycle.
        len = 0;
        for (int k = 0; k < N; k++) begin
            if (rs[k] > 5'd23 || rdst[k] > 5'd23) begin
                es[len] = '0; ed[len] = '0; edn[len] = 1'b0; eer[len] = 1'b1;
                len++;
            end else begin
                u = len;
                if (rs[k] == 5'd21)
                    while (!mr[u]) u++;
                for (int c = len; c <= u; c++) begin
                    es[c] = 24'd1 << rs[k]; ed[c] = '0; edn[c] = 1'b0; eer[c] = 1'b0;
                end
                es[u + 1] = 24'd1 << rs[k]; ed[u + 1] = 24'd1 << rdst[k];
                edn[u + 1] = 1'b1; eer[u + 1] = 1'b0;
                len = u + 2;
            end
        end
        do_reset();
        np = 0;
        for (int t = 0; t < len + 6; t++) begin
            if (t > 0) begin
                j = t - 2;
                if (j >= 0 && j < len) begin
                    xs = es[j]; xd = ed[j]; xdn = edn[j]; xer = eer[j];
                end else begin
                    xs = '0; xd = '0; xdn = 1'b0; xer = 1'b0;
                end
                checks++;
                if ({src_out, dst_in, xfer_done, cmd_err} !== {xs, xd, xdn, xer}) begin
                    errors++;
                    $display("FAIL random t=%0d got src=%h dst=%h done=%b err=%b exp src=%h dst=%h done=%b err=%b",
                             t, src_out, dst_in, xfer_done, cmd_err, xs, xd, xdn, xer);
                end
                checks++;
                if ($countones(src_out) > 1 || $countones(dst_in) > 1) begin
                    errors++;
                    $display("FAIL random_onehot t=%0d got src=%h dst=%h exp at most one bit each", t, src_out, dst_in);
                end
            end
            mem_ready = (t >= 2 && t - 2 < len) ? mr[t - 2] : 1'b1;
            if (np < N && cmd_ready === 1'b1) begin
                cmd_valid = 1'b1; cmd_src = rs[np]; cmd_dst = rdst[np];
                np++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (np != N || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got pushed=%0d busy=%b exp pushed=%0d busy=0", np, busy, N);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mdr_wait();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_clear_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
